dmem_responder: RTL and testbench

Memory-side responder serving load/store requests issued by the pipelined core's memory stage over a valid/ready request and response channel. It holds a word-addressed data store, adds a configurable access latency and supports byte-enabled writes. It flags misaligned and out-of-range accesses. At most one transaction is outstanding at a time.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/dmem_responder_if.sv | 27 ++
 rtl/dmem_array.sv | 56 +++++
 rtl/dmem_responder.sv | 112 +++++++++++
 tb/tb_dmem_responder.sv | 137 +++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory path: the responder FSM states, the
// word geometry and the alignment/range check used by core and responder.
package mem_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // idx_w is the word-index width; any set bit above the index is out of range.
    function automatic logic access_err(input logic [XLEN-1:0] addr,
                                        input int unsigned     idx_w);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[1:0] != 2'b00);
        out_of_range = ((addr >> (idx_w + 32'd2)) != {XLEN{1'b0}});
        return misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the core's memory stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
    import mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [BYTES-1:0]  req_be;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 word store with per-byte write enables and a registered read port.
// The read register doubles as the response data register: it is zeroed for
// stores and faulting accesses so it can drive the response bus directly.
module dmem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic                     re,
    input  logic                     clr,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [XLEN-1:0]          wdata,
    input  logic [BYTES-1:0]         be,
    output logic [XLEN-1:0]          rdata
);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] rdata_d;

    // Storage is deliberately not reset; only enabled byte lanes are written.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[idx];
        end else if (clr) begin
            rdata_d = {XLEN{1'b0}};
        end else begin
            rdata_d = rdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= {XLEN{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: accepts one load/store at a time, commits stores at
// the accept edge and answers after a fixed LATENCY with data or an error flag.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_responder_if.slave   bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 32'd1) ? $clog2(LATENCY) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 32'd1);

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              resp_valid_q;
    logic              resp_valid_d;
    logic              resp_err_q;
    logic              resp_err_d;

    logic              accept_s;
    logic              req_err_s;
    logic [IDX_W-1:0]  idx_s;
    logic [XLEN-1:0]   rdata_s;

    // rst_n is active-high here; ready is held low for the whole reset window.
    assign bus.req_ready = (state_q == IDLE) && !rst_n;
    assign accept_s      = bus.req_valid && bus.req_ready;
    assign req_err_s     = access_err(bus.req_addr, IDX_W);
    assign idx_s         = bus.req_addr[IDX_W+1:2];

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst_n),
        .we    (accept_s && bus.req_we && !req_err_s),
        .re    (accept_s && !bus.req_we && !req_err_s),
        .clr   (accept_s && (bus.req_we || req_err_s)),
        .idx   (idx_s),
        .wdata (bus.req_wdata),
        .be    (bus.req_be),
        .rdata (rdata_s)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        resp_err_d = resp_err_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    resp_err_d = req_err_s;
                    if (LATENCY == 32'd1) begin
                        state_d = RESP;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_valid_q && bus.resp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        // Registered copy of the next state's RESP decode keeps req_* off resp_valid.
        resp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = rdata_s;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH=1024, LATENCY=2) with hand-computed
// expected responses, timing and reset behaviour.
module tb_dmem_responder;
    import mem_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH   (1024),
        .LATENCY (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction issued from IDLE; hold = extra cycles of resp_ready=0.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        step();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'hA5A5_A5A5;
        bus.req_be    = 4'hF;
        check({tag, ".t1_valid"}, 32'(bus.resp_valid), 32'd0);
        step();
        check({tag, ".t2_valid_pre"}, 32'(bus.resp_valid), 32'd0);
        step();
        check({tag, ".valid"}, 32'(bus.resp_valid), 32'd1);
        check({tag, ".rdata"}, bus.resp_rdata, exp_rdata);
        check({tag, ".err"}, 32'(bus.resp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, ".hold_valid"}, 32'(bus.resp_valid), 32'd1);
            check({tag, ".hold_rdata"}, bus.resp_rdata, exp_rdata);
            check({tag, ".hold_err"}, 32'(bus.resp_err), 32'(exp_err));
            check({tag, ".hold_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        check({tag, ".done_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, ".done_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        n_vec          = 0;
        n_bad          = 0;
        rst_n          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.req_be     = 4'd0;
        bus.resp_ready = 1'b0;
        step();
        step();
        check("rst.valid", 32'(bus.resp_valid), 32'd0);
        check("rst.rdata", bus.resp_rdata, 32'd0);
        check("rst.err", 32'(bus.resp_err), 32'd0);
        check("rst.ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst.ready_after", 32'(bus.req_ready), 32'd1);

        xact("t1.st", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'd0, 1'b0, 0);
        xact("t1.ld", 1'b0, 32'h10, 32'd0, 4'b0000, 32'hDEAD_BEEF, 1'b0, 0);
        xact("t2.st", 1'b1, 32'h10, 32'h0000_AA00, 4'b0010, 32'd0, 1'b0, 0);
        xact("t2.ld", 1'b0, 32'h10, 32'd0, 4'b1111, 32'hDEAD_AAEF, 1'b0, 0);
        xact("t3.ld", 1'b0, 32'h10, 32'd0, 4'b0000, 32'hDEAD_AAEF, 1'b0, 5);
        xact("t4.st", 1'b1, 32'h13, 32'h1234_5678, 4'b1111, 32'd0, 1'b1, 0);
        xact("t4.ld", 1'b0, 32'h10, 32'd0, 4'b0000, 32'hDEAD_AAEF, 1'b0, 0);
        xact("t5.ld", 1'b0, 32'h1000, 32'd0, 4'b0000, 32'd0, 1'b1, 0);
        xact("t5.mis", 1'b0, 32'h12, 32'd0, 4'b0000, 32'd0, 1'b1, 0);
        xact("top.st", 1'b1, 32'hFFC, 32'hCAFE_F00D, 4'b1111, 32'd0, 1'b0, 0);
        xact("top.ld", 1'b0, 32'hFFC, 32'd0, 4'b0000, 32'hCAFE_F00D, 1'b0, 0);
        xact("be0.st", 1'b1, 32'h10, 32'h1111_1111, 4'b0000, 32'd0, 1'b0, 0);
        xact("be0.ld", 1'b0, 32'h10, 32'd0, 4'b0000, 32'hDEAD_AAEF, 1'b0, 0);

        // Reset during BUSY: response must be dropped, the store must persist.
        check("t6.ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h0000_0055;
        bus.req_be    = 4'b1111;
        step();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        rst_n         = 1'b1;
        step();
        check("t6.rst_valid", 32'(bus.resp_valid), 32'd0);
        check("t6.rst_ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6.ready_after", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6.no_valid", 32'(bus.resp_valid), 32'd0);
        end
        xact("t6.ld", 1'b0, 32'h20, 32'd0, 4'b0000, 32'h0000_0055, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
